// File: rtl/i2s_capture_interface.sv
// I2S receiver: synchronizes bck/lrck/data into capture_clk and assembles left/right samples into 32-bit words.
// Latency: 5 capture_clk edges from the LSB bck rise to out_valid. No stall: words arriving while out_full is high are dropped and flagged in overrun.
module i2s_capture_interface #(
    parameter int SAMPLE_BITS = 24
) (
    input  logic        capture_clk,
    input  logic        rst_n,
    input  logic        i2s_bck,
    input  logic        i2s_lrck,
    input  logic        i2s_data,
    input  logic        rx_en,
    input  logic        out_full,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        overrun,
    output logic        frame_err
);

    localparam int CW = $clog2(SAMPLE_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_BITS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic                   bck_s1_q, bck_s1_d, bck_s2_q, bck_s2_d, bck_s3_q, bck_s3_d;
    logic                   lrck_s1_q, lrck_s1_d, lrck_s2_q, lrck_s2_d;
    logic                   data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic                   evt_q, evt_d, evt_lrck_q, evt_lrck_d, evt_data_q, evt_data_d;
    logic [1:0]             state_q, state_d;
    logic                   lrck_prev_q, lrck_prev_d;
    logic                   ch_q, ch_d;
    logic [CW-1:0]          bitcnt_q, bitcnt_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    logic                   done_q, done_d;
    logic [31:0]            out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;
    logic                   slot_start;
    logic [31:0]            word;

    always_comb begin
        bck_s1_d  = i2s_bck;
        bck_s2_d  = bck_s1_q;
        bck_s3_d  = bck_s2_q;
        lrck_s1_d = i2s_lrck;
        lrck_s2_d = lrck_s1_q;
        data_s1_d = i2s_data;
        data_s2_d = data_s1_q;

        // lrck/data are captured from the same stage as the bck edge so all three stay aligned
        evt_d      = bck_s2_q & ~bck_s3_q;
        evt_lrck_d = evt_d ? lrck_s2_q : evt_lrck_q;
        evt_data_d = evt_d ? data_s2_q : evt_data_q;

        slot_start  = evt_q && (evt_lrck_q != lrck_prev_q);

        state_d     = state_q;
        lrck_prev_d = lrck_prev_q;
        ch_d        = ch_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;

        word    = {shift_q, {(32 - SAMPLE_BITS){1'b0}}};
        word[0] = ch_q;

        if (!rx_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_ARM;
                S_ARM:   if (slot_start && !evt_lrck_q) state_d = S_RUN;
                default: state_d = S_RUN;
            endcase
        end

        if (evt_q) begin
            lrck_prev_d = evt_lrck_q;
            if (slot_start) begin
                bitcnt_d = '0;
                ch_d     = evt_lrck_q;
                if (state_q == S_RUN && bitcnt_q < CNT_MAX) frame_err_d = 1'b1;
            end else if (bitcnt_q < CNT_MAX) begin
                shift_d  = {shift_q[SAMPLE_BITS-2:0], evt_data_q};
                bitcnt_d = bitcnt_q + CW'(1);
                if (state_q == S_RUN && bitcnt_q == CNT_MAX - CW'(1)) done_d = 1'b1;
            end
        end

        if (done_q && state_q == S_RUN && rx_en) begin
            if (!out_full) begin
                out_valid_d = 1'b1;
                out_data_d  = word;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (state_q == S_IDLE) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge capture_clk or negedge rst_n) begin
        if (!rst_n) begin
            bck_s1_q    <= 1'b0;
            bck_s2_q    <= 1'b0;
            bck_s3_q    <= 1'b0;
            lrck_s1_q   <= 1'b0;
            lrck_s2_q   <= 1'b0;
            data_s1_q   <= 1'b0;
            data_s2_q   <= 1'b0;
            evt_q       <= 1'b0;
            evt_lrck_q  <= 1'b0;
            evt_data_q  <= 1'b0;
            state_q     <= S_IDLE;
            lrck_prev_q <= 1'b0;
            ch_q        <= 1'b0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bck_s1_q    <= bck_s1_d;
            bck_s2_q    <= bck_s2_d;
            bck_s3_q    <= bck_s3_d;
            lrck_s1_q   <= lrck_s1_d;
            lrck_s2_q   <= lrck_s2_d;
            data_s1_q   <= data_s1_d;
            data_s2_q   <= data_s2_d;
            evt_q       <= evt_d;
            evt_lrck_q  <= evt_lrck_d;
            evt_data_q  <= evt_data_d;
            state_q     <= state_d;
            lrck_prev_q <= lrck_prev_d;
            ch_q        <= ch_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_capture_interface.sv
// Bench for i2s_capture_interface: 24-bit and 16-bit instances share one I2S stream, each checked against its own expected-word queue.
module tb_i2s_capture_interface;

    logic        capture_clk = 1'b0;
    logic        rst_n       = 1'b0;
    logic        i2s_bck     = 1'b0;
    logic        i2s_lrck    = 1'b0;
    logic        i2s_data    = 1'b0;
    logic        rx_en       = 1'b0;
    logic        out_full    = 1'b0;
    logic [31:0] out_data24, out_data16;
    logic        out_valid24, out_valid16;
    logic        overrun24, overrun16;
    logic        frame_err24, frame_err16;

    i2s_capture_interface #(.SAMPLE_BITS(24)) u_dut24 (
        .capture_clk (capture_clk),
        .rst_n       (rst_n),
        .i2s_bck     (i2s_bck),
        .i2s_lrck    (i2s_lrck),
        .i2s_data    (i2s_data),
        .rx_en       (rx_en),
        .out_full    (out_full),
        .out_data    (out_data24),
        .out_valid   (out_valid24),
        .overrun     (overrun24),
        .frame_err   (frame_err24)
    );

    i2s_capture_interface #(.SAMPLE_BITS(16)) u_dut16 (
        .capture_clk (capture_clk),
        .rst_n       (rst_n),
        .i2s_bck     (i2s_bck),
        .i2s_lrck    (i2s_lrck),
        .i2s_data    (i2s_data),
        .rx_en       (rx_en),
        .out_full    (out_full),
        .out_data    (out_data16),
        .out_valid   (out_valid16),
        .overrun     (overrun16),
        .frame_err   (frame_err16)
    );

    // capture_clk 100 MHz, bck 12.5 MHz: 8 capture cycles per bit
    always #5 capture_clk = ~capture_clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rise_cyc = 0;
    logic        bck_smp = 1'b0;
    logic [31:0] exp24_q[$];
    logic [31:0] exp16_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Index of the capture edge that first samples bck high
    always @(posedge capture_clk) begin
        cyc++;
        if (i2s_bck && !bck_smp) rise_cyc = cyc;
        bck_smp = i2s_bck;
    end

    always @(negedge capture_clk) begin
        if (out_valid24) begin
            if (exp24_q.size() == 0) check("spurious24", {31'b0, out_valid24}, 32'd0);
            else begin
                check("data24", out_data24, exp24_q.pop_front());
                check("lat24", cyc - rise_cyc, 32'd4);
            end
        end
        if (out_valid16) begin
            if (exp16_q.size() == 0) check("spurious16", {31'b0, out_valid16}, 32'd0);
            else begin
                check("data16", out_data16, exp16_q.pop_front());
                check("lat16", cyc - rise_cyc, 32'd4);
            end
        end
    end

    // One slot: lrck change with a dummy bit, then nbits MSB-first data bits from val
    task automatic send_slot(input logic lr, input logic [31:0] val, input int nbits, input bit emit);
        if (emit) begin
            exp24_q.push_back({val[31:8], 7'b0, lr});
            exp16_q.push_back({val[31:16], 15'b0, lr});
        end
        i2s_bck  = 1'b0;
        i2s_lrck = lr;
        i2s_data = 1'b0;
        #40 i2s_bck = 1'b1;
        #40;
        for (int i = 0; i < nbits; i++) begin
            i2s_bck  = 1'b0;
            i2s_data = val[31-i];
            #40 i2s_bck = 1'b1;
            #40;
        end
    endtask

    task automatic check_flags(input string tag, input logic ovr, input logic ferr);
        check({tag, "_ovr24"},  {31'b0, overrun24},   {31'b0, ovr});
        check({tag, "_ovr16"},  {31'b0, overrun16},   {31'b0, ovr});
        check({tag, "_ferr24"}, {31'b0, frame_err24}, {31'b0, ferr});
        check({tag, "_ferr16"}, {31'b0, frame_err16}, {31'b0, ferr});
    endtask

    initial begin
        #22;
        check("rst_data24",  out_data24, 32'd0);
        check("rst_data16",  out_data16, 32'd0);
        check("rst_valid24", {31'b0, out_valid24}, 32'd0);
        check_flags("rst", 1'b0, 1'b0);
        rst_n = 1'b1;
        #40;

        // Arm alignment: enable mid-left, that left and the next right are skipped
        send_slot(1'b1, 32'h0000_0000, 31, 1'b0);
        fork
            send_slot(1'b0, 32'h5555_5555, 31, 1'b0);
            begin #(80 * 10); rx_en = 1'b1; end
        join
        send_slot(1'b1, 32'h7777_7777, 31, 1'b0);

        // Basic capture
        send_slot(1'b0, 32'hABCD_EF00, 31, 1'b1);
        send_slot(1'b1, 32'h1234_5600, 31, 1'b1);
        send_slot(1'b0, 32'h8001_0000, 31, 1'b1);
        send_slot(1'b1, 32'hA5C3_F0FF, 31, 1'b1);
        check_flags("run", 1'b0, 1'b0);

        // Overrun on a right word
        send_slot(1'b0, 32'h1357_9B00, 31, 1'b1);
        out_full = 1'b1;
        send_slot(1'b1, 32'h2468_AC00, 31, 1'b0);
        out_full = 1'b0;
        check_flags("ovr", 1'b1, 1'b0);
        send_slot(1'b0, 32'h0F0F_0F00, 31, 1'b1);
        check_flags("ovr_hold", 1'b1, 1'b0);

        // Short left slot of 10 bits
        send_slot(1'b1, 32'h1111_1100, 31, 1'b1);
        send_slot(1'b0, 32'hFFFF_FF00, 10, 1'b0);
        send_slot(1'b1, 32'hC0FF_EE00, 31, 1'b1);
        check_flags("ferr", 1'b1, 1'b1);
        send_slot(1'b0, 32'h00AB_CD00, 31, 1'b1);
        send_slot(1'b1, 32'h6E5D_4C00, 31, 1'b1);

        // Abort after 12 bits, flags must clear
        fork
            send_slot(1'b0, 32'hDEAD_BE00, 31, 1'b0);
            begin #(80 * 13); rx_en = 1'b0; end
        join
        check_flags("abort", 1'b0, 1'b0);
        rx_en = 1'b1;
        send_slot(1'b1, 32'h4444_4400, 31, 1'b0);
        send_slot(1'b0, 32'h3141_5900, 31, 1'b1);
        send_slot(1'b1, 32'h2718_2800, 31, 1'b1);

        // Reset pulse mid-slot
        fork
            send_slot(1'b0, 32'h9999_9900, 31, 1'b0);
            begin
                #(80 * 8);
                rst_n = 1'b0;
                #1;
                check("mrst_data24",  out_data24, 32'd0);
                check("mrst_data16",  out_data16, 32'd0);
                check("mrst_valid24", {31'b0, out_valid24}, 32'd0);
                check_flags("mrst", 1'b0, 1'b0);
                #200 rst_n = 1'b1;
            end
        join
        send_slot(1'b1, 32'h5A5A_5A00, 31, 1'b0);
        send_slot(1'b0, 32'h600D_F00D, 31, 1'b1);
        send_slot(1'b1, 32'hBEEF_0100, 31, 1'b1);

        i2s_bck = 1'b0;
        #400;
        check("left24", exp24_q.size(), 32'd0);
        check("left16", exp16_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
